mac_pe_acc: RTL and testbench

- Parametrised second-generation systolic multiply-accumulate processing element.
- Forwards operands a/b to neighbouring PEs and computes a*b.
- Two runtime modes:
  - pass-through sum (weight-stationary style): s_out = c_in + a*b
  - output-stationary: a local accumulator sums a*b over many valid cycles
- Tiled into 2-D arrays by the array wrapper; widths, signedness and multiplier pipelining are configurable.

---
 rtl/mac_pe_acc.sv | 176 +++++++++++++++++
 tb/tb_mac_pe_acc.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mac_pe_acc.sv
// Systolic multiply-accumulate PE with operand forwarding, a pass-through sum mode and an
// output-stationary accumulate mode. Optional saturation is enabled by MAC_PE_ACC_SAT_EN.
module mac_pe_acc #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 16,
    parameter int SIGNED      = 0,
    parameter int MULT_STAGES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode_os,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic [ACC_WIDTH-1:0]  c_in,
    input  logic                  valid_bit_in,
    input  logic                  acc_clear,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic [ACC_WIDTH-1:0]  s_out,
    output logic                  valid_bit_out,
    output logic                  sat_flag
);

    localparam int PW = 2 * DATA_WIDTH;

    // Returns {clamped, sum}; the clamp bit can only be set when saturation is built in.
    function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] x,
                                                   input logic [ACC_WIDTH-1:0] y);
`ifdef MAC_PE_ACC_SAT_EN
        logic [ACC_WIDTH:0]   raw;
        logic                 ovf;
        logic [ACC_WIDTH-1:0] lim;
        raw = {1'b0, x} + {1'b0, y};
        if (SIGNED != 0) begin
            ovf = (x[ACC_WIDTH-1] == y[ACC_WIDTH-1]) && (raw[ACC_WIDTH-1] != x[ACC_WIDTH-1]);
            lim = x[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else begin
            ovf = raw[ACC_WIDTH];
            lim = {ACC_WIDTH{1'b1}};
        end
        sat_add = ovf ? {1'b1, lim} : {1'b0, raw[ACC_WIDTH-1:0]};
`else
        sat_add = {1'b0, x + y};
`endif
    endfunction

    logic [ACC_WIDTH-1:0]  p_ext_s;
    logic                  fin_v_s;
    logic                  fin_m_s;
    logic [ACC_WIDTH-1:0]  fin_p_s;
    logic [ACC_WIDTH-1:0]  fin_c_s;
    logic [ACC_WIDTH:0]    os_sum_s;
    logic [ACC_WIDTH:0]    ps_sum_s;

    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [ACC_WIDTH-1:0]  s_q, s_d;
    logic                  vo_q, vo_d;
    logic                  sat_q, sat_d;

    if (SIGNED != 0) begin : g_signed
        logic signed [PW-1:0] prod_s;
        assign prod_s  = PW'($signed(a_in)) * PW'($signed(b_in));
        assign p_ext_s = ACC_WIDTH'(prod_s);
    end else begin : g_unsigned
        logic [PW-1:0] prod_s;
        assign prod_s  = PW'(a_in) * PW'(b_in);
        assign p_ext_s = ACC_WIDTH'(prod_s);
    end

    if (MULT_STAGES == 0) begin : g_nopipe
        assign fin_v_s = valid_bit_in;
        assign fin_m_s = mode_os;
        assign fin_p_s = p_ext_s;
        assign fin_c_s = c_in;
    end else begin : g_pipe
        logic                 pv_q [MULT_STAGES];
        logic                 pm_q [MULT_STAGES];
        logic [ACC_WIDTH-1:0] pp_q [MULT_STAGES];
        logic [ACC_WIDTH-1:0] pc_q [MULT_STAGES];

        // Product tag pipeline: product, c_in and mode travel together with their valid.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < MULT_STAGES; i++) begin
                    pv_q[i] <= 1'b0;
                    pm_q[i] <= 1'b0;
                    pp_q[i] <= '0;
                    pc_q[i] <= '0;
                end
            end else begin
                pv_q[0] <= valid_bit_in;
                pm_q[0] <= mode_os;
                pp_q[0] <= p_ext_s;
                pc_q[0] <= c_in;
                for (int i = 1; i < MULT_STAGES; i++) begin
                    pv_q[i] <= pv_q[i-1];
                    pm_q[i] <= pm_q[i-1];
                    pp_q[i] <= pp_q[i-1];
                    pc_q[i] <= pc_q[i-1];
                end
            end
        end

        assign fin_v_s = pv_q[MULT_STAGES-1];
        assign fin_m_s = pm_q[MULT_STAGES-1];
        assign fin_p_s = pp_q[MULT_STAGES-1];
        assign fin_c_s = pc_q[MULT_STAGES-1];
    end

    assign os_sum_s = sat_add(acc_q, fin_p_s);
    assign ps_sum_s = sat_add(fin_c_s, fin_p_s);

    // Final stage: a clear coinciding with a mode-1 completion restarts the accumulator at p.
    always_comb begin
        acc_d = acc_q;
        s_d   = s_q;
        vo_d  = 1'b0;
        sat_d = acc_clear ? 1'b0 : sat_q;
        if (fin_v_s) begin
            vo_d = 1'b1;
            if (fin_m_s) begin
                if (acc_clear) begin
                    acc_d = fin_p_s;
                    s_d   = fin_p_s;
                end else begin
                    acc_d = os_sum_s[ACC_WIDTH-1:0];
                    s_d   = os_sum_s[ACC_WIDTH-1:0];
                    sat_d = sat_d | os_sum_s[ACC_WIDTH];
                end
            end else begin
                s_d   = ps_sum_s[ACC_WIDTH-1:0];
                sat_d = sat_d | ps_sum_s[ACC_WIDTH];
                if (acc_clear) begin
                    acc_d = '0;
                end else begin
                    acc_d = acc_q;
                end
            end
        end else begin
            if (acc_clear) begin
                acc_d = '0;
            end else begin
                acc_d = acc_q;
            end
        end
    end

    // Output, accumulator and forwarding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            s_q   <= '0;
            vo_q  <= 1'b0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            s_q   <= s_d;
            vo_q  <= vo_d;
            sat_q <= sat_d;
            if (valid_bit_in) begin
                a_q <= a_in;
                b_q <= b_in;
            end
        end
    end

    assign a_out         = a_q;
    assign b_out         = b_q;
    assign s_out         = s_q;
    assign valid_bit_out = vo_q;
    assign sat_flag      = sat_q;

endmodule

// File: tb/tb_mac_pe_acc.sv
// Directed bench for mac_pe_acc: three instances (unsigned/0 stages, unsigned/2 stages,
// signed/0 stages) share one stimulus stream; expectations are hand-computed constants.
module tb_mac_pe_acc;

    logic        clk;
    logic        rst_n;
    logic        mode_os;
    logic [7:0]  a_in, b_in;
    logic [15:0] c_in;
    logic        valid_bit_in;
    logic        acc_clear;

    logic [7:0]  u0_a, u0_b, u2_a, u2_b, us_a, us_b;
    logic [15:0] u0_s, u2_s, us_s;
    logic        u0_v, u2_v, us_v, u0_sat, u2_sat, us_sat;

    int n_chk = 0;
    int n_err = 0;

`ifdef MAC_PE_ACC_SAT_EN
    localparam logic [15:0] EXP_OV1 = 16'hFFFF;
    localparam logic [15:0] EXP_OV0 = 16'hFFFF;
    localparam logic        EXP_SAT = 1'b1;
`else
    localparam logic [15:0] EXP_OV1 = 16'hFC02;
    localparam logic [15:0] EXP_OV0 = 16'hFE00;
    localparam logic        EXP_SAT = 1'b0;
`endif

    mac_pe_acc #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(0), .MULT_STAGES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .mode_os(mode_os), .a_in(a_in), .b_in(b_in), .c_in(c_in),
        .valid_bit_in(valid_bit_in), .acc_clear(acc_clear), .a_out(u0_a), .b_out(u0_b),
        .s_out(u0_s), .valid_bit_out(u0_v), .sat_flag(u0_sat));

    mac_pe_acc #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(0), .MULT_STAGES(2)) u2 (
        .clk(clk), .rst_n(rst_n), .mode_os(mode_os), .a_in(a_in), .b_in(b_in), .c_in(c_in),
        .valid_bit_in(valid_bit_in), .acc_clear(acc_clear), .a_out(u2_a), .b_out(u2_b),
        .s_out(u2_s), .valid_bit_out(u2_v), .sat_flag(u2_sat));

    mac_pe_acc #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(1), .MULT_STAGES(0)) us (
        .clk(clk), .rst_n(rst_n), .mode_os(mode_os), .a_in(a_in), .b_in(b_in), .c_in(c_in),
        .valid_bit_in(valid_bit_in), .acc_clear(acc_clear), .a_out(us_a), .b_out(us_b),
        .s_out(us_s), .valid_bit_out(us_v), .sat_flag(us_sat));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] c, input logic v);
        mode_os = m; a_in = a; b_in = b; c_in = c; valid_bit_in = v;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; acc_clear = 1'b0;
        drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if (u0_s !== 16'd0 || u0_v !== 1'b0 || u0_a !== 8'd0 || u0_sat !== 1'b0) begin n_err++; $display("FAIL reset_state: s=%h v=%b a=%h sat=%b want all 0", u0_s, u0_v, u0_a, u0_sat); end
        tick;
        rst_n = 1'b1;
        tick;
        n_chk++; if (u0_v !== 1'b0 || u2_v !== 1'b0) begin n_err++; $display("FAIL reset_no_valid: u0_v=%b u2_v=%b want 0", u0_v, u2_v); end
    endtask

    task automatic test_mode0;
        drive(1'b0, 8'd2, 8'd5, 16'd3, 1'b1);
        tick;
        n_chk++; if (u0_s !== 16'd13 || u0_v !== 1'b1) begin n_err++; $display("FAIL m0_sum1: s=%0d v=%b want 13 1", u0_s, u0_v); end
        n_chk++; if (u0_a !== 8'd2 || u0_b !== 8'd5) begin n_err++; $display("FAIL m0_fwd1: a=%0d b=%0d want 2 5", u0_a, u0_b); end
        drive(1'b0, 8'd0, 8'd2, 16'd13, 1'b1);
        tick;
        n_chk++; if (u0_s !== 16'd13 || u0_v !== 1'b1 || u0_a !== 8'd0 || u0_b !== 8'd2) begin n_err++; $display("FAIL m0_sum2: s=%0d v=%b a=%0d b=%0d want 13 1 0 2", u0_s, u0_v, u0_a, u0_b); end
    endtask

    task automatic test_valid_gating;
        drive(1'b0, 8'd1, 8'd9, 16'd77, 1'b0);
        tick;
        n_chk++; if (u0_a !== 8'd0 || u0_b !== 8'd2 || u0_v !== 1'b0 || u0_s !== 16'd13) begin n_err++; $display("FAIL gating: a=%0d b=%0d v=%b s=%0d want 0 2 0 13", u0_a, u0_b, u0_v, u0_s); end
    endtask

    task automatic test_accumulate;
        tick; tick;
        acc_clear = 1'b1; tick; acc_clear = 1'b0;
        n_chk++; if (u2_v !== 1'b0) begin n_err++; $display("FAIL clear_novalid: v=%b want 0", u2_v); end
        drive(1'b1, 8'd3, 8'd4, 16'd999, 1'b1); tick;
        n_chk++; if (u0_s !== 16'd12 || u2_v !== 1'b0) begin n_err++; $display("FAIL acc_lat1: u0_s=%0d u2_v=%b want 12 0", u0_s, u2_v); end
        drive(1'b1, 8'd5, 8'd6, 16'd999, 1'b1); tick;
        n_chk++; if (u0_s !== 16'd42 || u2_v !== 1'b0) begin n_err++; $display("FAIL acc_lat2: u0_s=%0d u2_v=%b want 42 0", u0_s, u2_v); end
        drive(1'b1, 8'd7, 8'd1, 16'd999, 1'b1); tick;
        n_chk++; if (u2_s !== 16'd12 || u2_v !== 1'b1) begin n_err++; $display("FAIL acc_c3: s=%0d v=%b want 12 1", u2_s, u2_v); end
        drive(1'b1, 8'd0, 8'd0, 16'd0, 1'b0); tick;
        n_chk++; if (u2_s !== 16'd42 || u2_v !== 1'b1) begin n_err++; $display("FAIL acc_c4: s=%0d v=%b want 42 1", u2_s, u2_v); end
        tick;
        n_chk++; if (u2_s !== 16'd49 || u2_v !== 1'b1) begin n_err++; $display("FAIL acc_c5: s=%0d v=%b want 49 1", u2_s, u2_v); end
        tick;
        n_chk++; if (u2_s !== 16'd49 || u2_v !== 1'b0) begin n_err++; $display("FAIL acc_hold: s=%0d v=%b want 49 0", u2_s, u2_v); end
        drive(1'b1, 8'd2, 8'd2, 16'd0, 1'b1); tick;
        drive(1'b1, 8'd0, 8'd0, 16'd0, 1'b0); tick;
        acc_clear = 1'b1; tick; acc_clear = 1'b0;
        n_chk++; if (u2_s !== 16'd4 || u2_v !== 1'b1) begin n_err++; $display("FAIL clear_coinc: s=%0d v=%b want 4 1", u2_s, u2_v); end
        drive(1'b1, 8'd1, 8'd1, 16'd0, 1'b1); tick;
        drive(1'b1, 8'd0, 8'd0, 16'd0, 1'b0); tick; tick;
        n_chk++; if (u2_s !== 16'd5 || u2_v !== 1'b1) begin n_err++; $display("FAIL clear_restart: s=%0d v=%b want 5 1", u2_s, u2_v); end
    endtask

    task automatic test_signed;
        drive(1'b0, 8'hFD, 8'd7, 16'd5, 1'b1); tick;
        n_chk++; if (us_s !== 16'hFFF0 || us_v !== 1'b1) begin n_err++; $display("FAIL signed_neg: s=%h v=%b want fff0 1", us_s, us_v); end
        drive(1'b0, 8'h80, 8'h80, 16'd0, 1'b1); tick;
        n_chk++; if (us_s !== 16'h4000) begin n_err++; $display("FAIL signed_minmin: s=%h want 4000", us_s); end
        drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0); tick; tick;
    endtask

    task automatic test_overflow;
        acc_clear = 1'b1; tick; acc_clear = 1'b0;
        drive(1'b1, 8'd255, 8'd255, 16'd0, 1'b1); tick;
        n_chk++; if (u0_s !== 16'hFE01) begin n_err++; $display("FAIL ovf_first: s=%h want fe01", u0_s); end
        tick;
        n_chk++; if (u0_s !== EXP_OV1 || u0_sat !== EXP_SAT) begin n_err++; $display("FAIL ovf_acc: s=%h sat=%b want %h %b", u0_s, u0_sat, EXP_OV1, EXP_SAT); end
        drive(1'b1, 8'd0, 8'd0, 16'd0, 1'b0); tick;
        n_chk++; if (u0_sat !== EXP_SAT || u0_v !== 1'b0) begin n_err++; $display("FAIL sat_hold: sat=%b v=%b want %b 0", u0_sat, u0_v, EXP_SAT); end
        drive(1'b0, 8'd255, 8'd255, 16'hFFFF, 1'b1); tick;
        n_chk++; if (u0_s !== EXP_OV0 || u0_sat !== EXP_SAT) begin n_err++; $display("FAIL ovf_m0: s=%h sat=%b want %h %b", u0_s, u0_sat, EXP_OV0, EXP_SAT); end
        drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
        acc_clear = 1'b1; tick; acc_clear = 1'b0;
        n_chk++; if (u0_sat !== 1'b0 || u0_v !== 1'b0 || u0_s !== EXP_OV0) begin n_err++; $display("FAIL sat_clear: sat=%b v=%b s=%h want 0 0 %h", u0_sat, u0_v, u0_s, EXP_OV0); end
    endtask

    task automatic test_back_to_back;
        tick; tick;
        drive(1'b1, 8'd2, 8'd3, 16'd500, 1'b1); tick;
        drive(1'b0, 8'd1, 8'd1, 16'd100, 1'b1); tick;
        drive(1'b1, 8'd4, 8'd1, 16'd700, 1'b1); tick;
        n_chk++; if (u2_s !== 16'd6 || u2_v !== 1'b1) begin n_err++; $display("FAIL b2b_1: s=%0d v=%b want 6 1", u2_s, u2_v); end
        drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0); tick;
        n_chk++; if (u2_s !== 16'd101 || u2_v !== 1'b1) begin n_err++; $display("FAIL b2b_2: s=%0d v=%b want 101 1", u2_s, u2_v); end
        tick;
        n_chk++; if (u2_s !== 16'd10 || u2_v !== 1'b1) begin n_err++; $display("FAIL b2b_3: s=%0d v=%b want 10 1", u2_s, u2_v); end
        tick;
    endtask

    task automatic test_reset_midflight;
        drive(1'b1, 8'd1, 8'd1, 16'd0, 1'b1); tick;
        drive(1'b1, 8'd1, 8'd1, 16'd0, 1'b1); tick;
        drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        n_chk++; if (u2_s !== 16'd0 || u2_v !== 1'b0 || u2_a !== 8'd0 || u2_b !== 8'd0) begin n_err++; $display("FAIL rst_mid: s=%0d v=%b a=%0d b=%0d want 0", u2_s, u2_v, u2_a, u2_b); end
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_chk++; if (u2_v !== 1'b0) begin n_err++; $display("FAIL rst_flush%0d: v=%b want 0", i, u2_v); end
        end
        drive(1'b1, 8'd3, 8'd3, 16'd0, 1'b1); tick;
        drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0); tick; tick;
        n_chk++; if (u2_s !== 16'd9 || u2_v !== 1'b1) begin n_err++; $display("FAIL rst_resume: s=%0d v=%b want 9 1", u2_s, u2_v); end
    endtask

    initial begin
        test_reset;
        test_mode0;
        test_valid_gating;
        test_accumulate;
        test_signed;
        test_overflow;
        test_back_to_back;
        test_reset_midflight;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
